// File: rtl/data_rx_pkg.sv
// Shared definitions for the data_sr receive sequencer.
// Holds the frame geometry, the CRC-16 polynomial, the start-bit timeout
// and the controller state encoding.
package data_rx_pkg;

  localparam int          DATA_BITS  = 64;
  localparam int          CRC_BITS   = 16;
  localparam logic [15:0] CRC_POLY   = 16'h1021;
  localparam int          TIMEOUT    = 1024;
  // start bit + payload + CRC + end bit = 82
  localparam int          FRAME_BITS = 1 + DATA_BITS + CRC_BITS + 1;
  localparam int          TCNT_W     = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_DATA       = 3'd2,
    S_CRC        = 3'd3,
    S_END        = 3'd4,
    S_DONE       = 3'd5
  } state_t;

endpackage

// File: rtl/data_rx_ctrl_crc16_serial.sv
// Bit-serial CRC-16 register (MSB-first, initial value 0).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr         synchronous clear to 0 (has priority over en)
//   en          advance one bit
//   shift_only  when set with en, shift left with 0 fill and no feedback
//               (used to stream the computed CRC out for comparison)
//   din         serial data bit
//   crc         current register contents
module crc16_serial
  import data_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        shift_only,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      if (shift_only) crc <= {crc[14:0], 1'b0};
      else            crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/data_rx_ctrl.sv
// Receive-side sequencer for the 82-bit serial shift register data_sr.
// Frames one block (start 0, 64 data bits MSB-first, 16 CRC bits, end 1),
// drives the data_sr shift enable / select and checks the CRC on the fly.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_data       serial line (idles high), sampled only on bit_strobe
//   bit_strobe    one-cycle pulse per bit period
//   rx_start      arms reception of one block (ignored while busy)
//   rx_ack        host acknowledge of a completed block
//   data_shift    combinational shift enable for data_sr
//   SR_select     registered select of data_sr as shift target
//   busy          controller not in IDLE
//   blk_valid     block finished; crc_err/end_err/timeout are valid
//   crc_err       received CRC differs from the computed CRC
//   end_err       end bit sampled as 0
//   timeout       no start bit within TIMEOUT strobes
//   fsm_state     current controller state, for observation
//
// Handshake: blk_valid is held high in DONE together with stable status and
// frozen data_sr contents; the block is consumed on the first cycle where
// blk_valid and rx_ack are both high, which returns to IDLE and clears all
// status in that same edge. rx_ack in any other state has no effect.
module data_rx_ctrl
  import data_rx_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_data,
  input  logic   bit_strobe,
  input  logic   rx_start,
  input  logic   rx_ack,
  output logic   data_shift,
  output logic   SR_select,
  output logic   busy,
  output logic   blk_valid,
  output logic   crc_err,
  output logic   end_err,
  output logic   timeout,
  output state_t fsm_state
);

  state_t              state, state_n;
  logic [6:0]          bit_cnt, bit_cnt_n;
  logic [TCNT_W-1:0]   tcnt, tcnt_n;
  logic                mism, mism_n;
  logic                crc_err_n, end_err_n, timeout_n, sr_select_n;
  logic                crc_clr, crc_en, crc_shift_only;
  logic [15:0]         crc;

  crc16_serial u_crc (
    .clk        (clk),
    .rst        (rst),
    .clr        (crc_clr),
    .en         (crc_en),
    .shift_only (crc_shift_only),
    .din        (in_data),
    .crc        (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      tcnt      <= '0;
      mism      <= 1'b0;
      crc_err   <= 1'b0;
      end_err   <= 1'b0;
      timeout   <= 1'b0;
      SR_select <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      tcnt      <= tcnt_n;
      mism      <= mism_n;
      crc_err   <= crc_err_n;
      end_err   <= end_err_n;
      timeout   <= timeout_n;
      SR_select <= sr_select_n;
    end
  end

  always_comb begin
    state_n        = state;
    bit_cnt_n      = bit_cnt;
    tcnt_n         = tcnt;
    mism_n         = mism;
    crc_err_n      = crc_err;
    end_err_n      = end_err;
    timeout_n      = timeout;
    crc_clr        = 1'b0;
    crc_en         = 1'b0;
    crc_shift_only = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_start) begin
          state_n   = S_WAIT_START;
          tcnt_n    = '0;
          bit_cnt_n = '0;
          mism_n    = 1'b0;
          crc_clr   = 1'b1;
        end
      end
      S_WAIT_START: begin
        if (bit_strobe) begin
          if (!in_data) begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
          end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            timeout_n = 1'b1;
            state_n   = S_DONE;
          end else begin
            tcnt_n = tcnt + TCNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (bit_strobe) begin
          crc_en = 1'b1;
          if (bit_cnt == 7'(DATA_BITS - 1)) begin
            state_n   = S_CRC;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 7'd1;
          end
        end
      end
      S_CRC: begin
        if (bit_strobe) begin
          // Stream the computed CRC out MSB-first against the received bits.
          if (in_data != crc[15]) mism_n = 1'b1;
          crc_en         = 1'b1;
          crc_shift_only = 1'b1;
          if (bit_cnt == 7'(CRC_BITS - 1)) begin
            state_n   = S_END;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 7'd1;
          end
        end
      end
      S_END: begin
        if (bit_strobe) begin
          end_err_n = ~in_data;
          crc_err_n = mism;
          state_n   = S_DONE;
        end
      end
      S_DONE: begin
        if (rx_ack) begin
          state_n   = S_IDLE;
          crc_err_n = 1'b0;
          end_err_n = 1'b0;
          timeout_n = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Registered from the next state so data_sr stays frozen in IDLE/DONE.
    sr_select_n = (state_n == S_WAIT_START) || (state_n == S_DATA) ||
                  (state_n == S_CRC) || (state_n == S_END);
  end

  // The start bit is shifted in too, so a good block gives exactly 82 shifts.
  assign data_shift = bit_strobe &&
                      ((state == S_DATA) || (state == S_CRC) || (state == S_END) ||
                       ((state == S_WAIT_START) && !in_data));
  assign busy       = (state != S_IDLE);
  assign blk_valid  = (state == S_DONE);
  assign fsm_state  = state;

endmodule
